mastermind_turn_fsm: RTL and testbench
======================================

# mastermind_turn_fsm

Parametrised turn and role sequencer for the electronic Mastermind machine. It supports N players rotating through code-maker and code-breaker roles over a fixed number of rounds, and counts guesses per round against a limit. It reports which player must act and in which role, and flags round and game completion to the scoring and display logic. It sits between the player input controls and the peg comparator.

## Interface
- `N_PLAYERS`, default 2: number of players, ≥2; `PW = max(1, $clog2(N_PLAYERS))`.
- `MAX_GUESSES`, default 10: guesses allowed per round, ≥1; `GW = $clog2(MAX_GUESSES+1)`.
- `N_ROUNDS`, default 4: rounds per game, ≥1; `RW = max(1, $clog2(N_ROUNDS))`.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a game; honoured only in IDLE or GAME_OVER.
- `take_code`  in  1  maker commits the secret code; honoured only in MAKE.
- `guess_valid`  in  1  breaker submits a guess; honoured only in BREAK.
- `guess_hit`  in  1  comparator reports all pegs exact; sampled only with an accepted `guess_valid`.
- `abort`  in  1  abandons the game; honoured in any state except IDLE.
- `maker_id`  out  PW  index of the current code maker.
- `breaker_id`  out  PW  index of the current code breaker, equal to `(maker_id+1) mod N_PLAYERS`.
- `player_active`  out  N_PLAYERS  one-hot vector of the player expected to act.
- `code_maker`  out  1  high in MAKE.
- `code_breaker`  out  1  high in BREAK.
- `guess_cnt`  out  GW  accepted guesses in the current round.
- `round_cnt`  out  RW  current round index.
- `round_done`  out  1  one-cycle pulse, high in ROUND_END.
- `breaker_won`  out  1  last round ended on a hit; valid in ROUND_END and GAME_OVER.
- `game_over`  out  1  level, high in GAME_OVER.

## Operation
- States: IDLE, MAKE, BREAK, ROUND_END, GAME_OVER.
- IDLE → MAKE on `start`. The transition clears `round_cnt`, `guess_cnt`, `maker_id` and `breaker_won`.
- MAKE → BREAK on `take_code`.
- BREAK, on `guess_valid`:
  - `guess_cnt` increments.
  - If `guess_hit`, or if `guess_cnt == MAX_GUESSES-1` before the increment, go to ROUND_END and set `breaker_won = guess_hit`.
  - Otherwise stay in BREAK.
- ROUND_END is always exactly one cycle.
  - If `round_cnt == N_ROUNDS-1`, go to GAME_OVER.
  - Otherwise go to MAKE: `round_cnt`+1, `guess_cnt` = 0, `breaker_won` = 0, `maker_id` increments and wraps from N_PLAYERS-1 to 0.
- GAME_OVER → MAKE on `start`, with the same clearing as from IDLE.
- `abort` moves any non-IDLE state to IDLE and clears every counter and flag.
- Priority: `reset` > `abort` > state-specific input.
- Inputs arriving in a state where they are not honoured are ignored. For example, `guess_valid` in MAKE does not change `guess_cnt`, and `start` in BREAK has no effect.
- `player_active`:
  - MAKE: `1 << maker_id`.
  - BREAK: `1 << breaker_id`.
  - All other states: 0.
- All counters wrap only as stated above and never overflow. `guess_cnt` peaks at MAX_GUESSES.

## Timing
- Moore outputs: every output is decoded from registered state and counters, with no combinational input-to-output path.
- Latency: an honoured input on edge k is reflected in the outputs after edge k.
- Reset: applied on the edge where `reset` is high, including mid-round. After that edge:
  - State is IDLE.
  - `maker_id` = 0 and `breaker_id` = 1.
  - All other outputs are 0.
- A winning guess on edge k gives `round_done` = 1 for the cycle after k only. MAKE for the next round follows one edge later.
- Simultaneous `guess_hit` on the MAX_GUESSES-th guess counts as a hit (`breaker_won` = 1).

## Structure
- Shared package `mastermind_pkg`: state enum `turn_state_t`, and the width helper functions for PW, GW and RW.
- Sub-module `mm_wrap_counter`, parametrised by modulus, with `clr`, `inc` and `wrap` outputs. It is instantiated three times: for `maker_id`, `guess_cnt` and `round_cnt`.
- FSM and output decode live in `mastermind_turn_fsm`.

## Test plan
- Reset, then `start`, then `take_code` (defaults): outputs are all 0 except `breaker_id` = 1. After `start`: `code_maker` = 1 and `player_active` = 2'b01. After `take_code`: `code_breaker` = 1 and `player_active` = 2'b10.
- Three guesses with `guess_hit` on the third: one cycle with `round_done` = 1, `breaker_won` = 1, `guess_cnt` = 3. The next cycle shows MAKE with `maker_id` = 1, `breaker_id` = 0, `round_cnt` = 1, `guess_cnt` = 0.
- Ten guesses with no hit: ROUND_END with `guess_cnt` = 10 and `breaker_won` = 0. An eleventh `guess_valid` during ROUND_END is ignored.
- Four complete rounds: `game_over` = 1 after the fourth ROUND_END. `start` then gives MAKE with `round_cnt` = 0 and `maker_id` = 0.
- `abort` at `guess_cnt` = 5 in BREAK: IDLE with counters at 0 on the next edge. Repeat with `reset` instead; the result is identical, and there is no effect before the clock edge.
- `N_PLAYERS` = 3 over five rounds:
  - Maker sequence 0, 1, 2, 0, 1; breaker sequence 1, 2, 0, 1, 2.
  - `guess_valid` asserted in MAKE leaves `guess_cnt` at 0.

Source files
------------

// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind turn sequencer.
//   turn_state_t : sequencer states
//   pw_of/gw_of/rw_of : widths of the player, guess and round fields
package mastermind_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MAKE,
      BREAK,
      ROUND_END,
      GAME_OVER
   } turn_state_t;

   // Player index width: max(1, clog2(n_players)).
   function automatic int pw_of(input int n_players);
      int w;
      w = $clog2(n_players);
      return (w < 1) ? 1 : w;
   endfunction

   // Guess count width: must hold the value MAX_GUESSES itself.
   function automatic int gw_of(input int max_guesses);
      return $clog2(max_guesses + 1);
   endfunction

   // Round index width: max(1, clog2(n_rounds)).
   function automatic int rw_of(input int n_rounds);
      int w;
      w = $clog2(n_rounds);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mm_wrap_counter.sv
// Modulo-MODULUS up counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   clr        : force count to 0 (wins over inc)
//   inc        : advance by one, wrapping from MODULUS-1 to 0
//   count      : current value
//   wrap       : high while count == MODULUS-1
module mm_wrap_counter #(
   parameter int MODULUS = 2,
   parameter int W       = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(MODULUS - 1);

   assign wrap = (count == LAST);

   // NOTE: registered state is written with non-blocking assignments so every
   // flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= wrap ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/mastermind_turn_fsm.sv
// Turn and role sequencer for the electronic Mastermind machine.
//   clk, reset   : clock, synchronous active-high reset
//   start        : begin a game (IDLE / GAME_OVER only)
//   take_code    : maker commits the secret code (MAKE only)
//   guess_valid  : breaker submits a guess (BREAK only)
//   guess_hit    : all pegs exact, qualified by guess_valid
//   abort        : abandon the game from any non-IDLE state
//   maker_id     : current code maker
//   breaker_id   : current code breaker, (maker_id+1) mod N_PLAYERS
//   player_active: one-hot player expected to act
//   code_maker   : high in MAKE
//   code_breaker : high in BREAK
//   guess_cnt    : accepted guesses this round
//   round_cnt    : current round index
//   round_done   : high for the single ROUND_END cycle
//   breaker_won  : last round ended on a hit
//   game_over    : high in GAME_OVER
// All outputs derive from registers only; no input reaches an output
// without passing through a clock edge.
module mastermind_turn_fsm
   import mastermind_pkg::*;
#(
   parameter int  N_PLAYERS   = 2,
   parameter int  MAX_GUESSES = 10,
   parameter int  N_ROUNDS    = 4,
   localparam int PW          = pw_of(N_PLAYERS),
   localparam int GW          = gw_of(MAX_GUESSES),
   localparam int RW          = rw_of(N_ROUNDS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 take_code,
   input  logic                 guess_valid,
   input  logic                 guess_hit,
   input  logic                 abort,
   output logic [PW-1:0]        maker_id,
   output logic [PW-1:0]        breaker_id,
   output logic [N_PLAYERS-1:0] player_active,
   output logic                 code_maker,
   output logic                 code_breaker,
   output logic [GW-1:0]        guess_cnt,
   output logic [RW-1:0]        round_cnt,
   output logic                 round_done,
   output logic                 breaker_won,
   output logic                 game_over
);

   localparam logic [GW-1:0] GUESS_LAST = GW'(MAX_GUESSES - 1);

   turn_state_t state;
   turn_state_t state_nxt;
   logic        won_nxt;
   logic        clear_all;
   logic        next_round;
   logic        guess_inc;
   logic        maker_wrap;
   logic        round_wrap;
   logic        guess_wrap_unused;

   // ---------------- counters ----------------
   mm_wrap_counter #(.MODULUS(N_PLAYERS), .W(PW)) u_maker (
      .clk   (clk),
      .reset (reset),
      .clr   (clear_all),
      .inc   (next_round),
      .count (maker_id),
      .wrap  (maker_wrap)
   );

   // Modulus MAX_GUESSES+1 so the count can rest at MAX_GUESSES; the round
   // always ends on that guess, so the counter never actually wraps.
   mm_wrap_counter #(.MODULUS(MAX_GUESSES + 1), .W(GW)) u_guess (
      .clk   (clk),
      .reset (reset),
      .clr   (clear_all | next_round),
      .inc   (guess_inc),
      .count (guess_cnt),
      .wrap  (guess_wrap_unused)
   );

   mm_wrap_counter #(.MODULUS(N_ROUNDS), .W(RW)) u_round (
      .clk   (clk),
      .reset (reset),
      .clr   (clear_all),
      .inc   (next_round),
      .count (round_cnt),
      .wrap  (round_wrap)
   );

   // ---------------- next-state logic ----------------
   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      won_nxt    = breaker_won;
      clear_all  = 1'b0;
      next_round = 1'b0;
      guess_inc  = 1'b0;
      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
         won_nxt   = 1'b0;
         clear_all = 1'b1;
      end else begin
         case (state)
            IDLE, GAME_OVER: begin
               if (start) begin
                  state_nxt = MAKE;
                  won_nxt   = 1'b0;
                  clear_all = 1'b1;
               end
            end
            MAKE: begin
               if (take_code) state_nxt = BREAK;
            end
            BREAK: begin
               if (guess_valid) begin
                  guess_inc = 1'b1;
                  // A hit on the final allowed guess still counts as a hit.
                  if (guess_hit || (guess_cnt == GUESS_LAST)) begin
                     state_nxt = ROUND_END;
                     won_nxt   = guess_hit;
                  end
               end
            end
            ROUND_END: begin
               if (round_wrap) begin
                  state_nxt = GAME_OVER;
               end else begin
                  state_nxt  = MAKE;
                  won_nxt    = 1'b0;
                  next_round = 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               won_nxt   = 1'b0;
               clear_all = 1'b1;
            end
         endcase
      end
   end

   // ---------------- state and registered flags ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         breaker_won  <= 1'b0;
         code_maker   <= 1'b0;
         code_breaker <= 1'b0;
         round_done   <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         state        <= state_nxt;
         breaker_won  <= won_nxt;
         code_maker   <= (state_nxt == MAKE);
         code_breaker <= (state_nxt == BREAK);
         round_done   <= (state_nxt == ROUND_END);
         game_over    <= (state_nxt == GAME_OVER);
      end
   end

   // ---------------- role decode ----------------
   assign breaker_id = maker_wrap ? '0 : maker_id + PW'(1);

   always_comb begin
      player_active = '0;
      if (code_maker) begin
         player_active[maker_id] = 1'b1;
      end else if (code_breaker) begin
         player_active[breaker_id] = 1'b1;
      end
   end

endmodule

// File: tb/tb_mastermind_turn_fsm.sv
// Self-checking bench for mastermind_turn_fsm.
// Two instances share one input set: the default configuration and a
// three-player, five-round configuration. A behavioural model per instance
// pushes expected outputs to a scoreboard queue at drive time; entries are
// popped and compared one time unit after the clock edge. Outputs are also
// compared just before each edge against the previous expectation, so an
// input that leaks into an output before the edge is caught.
module tb_mastermind_turn_fsm;

   localparam int MG = 10;

   typedef struct {
      logic reset, abort, start, take, gv, hit;
   } inp_t;

   typedef struct {
      int cm, cb, rd, bw, go, mk, br, pa, gc, rc;
   } out_t;

   typedef struct {
      inp_t in;
      out_t exp;
   } vec_t;

   typedef struct {
      int    dut;
      out_t  exp;
      string tag;
   } sb_t;

   logic clk = 1'b0;
   logic reset = 1'b0, abort = 1'b0, start = 1'b0;
   logic take_code = 1'b0, guess_valid = 1'b0, guess_hit = 1'b0;

   logic [0:0] maker0, breaker0;
   logic [1:0] pa0;
   logic [3:0] gc0;
   logic [1:0] rc0;
   logic       cm0, cb0, rd0, bw0, go0;

   logic [1:0] maker1, breaker1;
   logic [2:0] pa1;
   logic [3:0] gc1;
   logic [2:0] rc1;
   logic       cm1, cb1, rd1, bw1, go1;

   int   n_pass = 0;
   int   n_total = 0;
   bit   first = 1'b1;
   sb_t  sbq[$];
   vec_t tbl[10];

   int m_st[2], m_mk[2], m_gc[2], m_rc[2], m_bw[2];
   int np[2] = '{2, 3};
   int nr[2] = '{4, 5};
   int mk_seq[5] = '{0, 1, 2, 0, 1};
   int br_seq[5] = '{1, 2, 0, 1, 2};

   always #5 clk = ~clk;

   mastermind_turn_fsm dut0 (
      .clk(clk), .reset(reset), .start(start), .take_code(take_code),
      .guess_valid(guess_valid), .guess_hit(guess_hit), .abort(abort),
      .maker_id(maker0), .breaker_id(breaker0), .player_active(pa0),
      .code_maker(cm0), .code_breaker(cb0), .guess_cnt(gc0), .round_cnt(rc0),
      .round_done(rd0), .breaker_won(bw0), .game_over(go0)
   );

   mastermind_turn_fsm #(.N_PLAYERS(3), .MAX_GUESSES(MG), .N_ROUNDS(5)) dut3 (
      .clk(clk), .reset(reset), .start(start), .take_code(take_code),
      .guess_valid(guess_valid), .guess_hit(guess_hit), .abort(abort),
      .maker_id(maker1), .breaker_id(breaker1), .player_active(pa1),
      .code_maker(cm1), .code_breaker(cb1), .guess_cnt(gc1), .round_cnt(rc1),
      .round_done(rd1), .breaker_won(bw1), .game_over(go1)
   );

   // ---------------- helpers ----------------
   function automatic inp_t mi(input bit r, a, s, t, g, h);
      inp_t x;
      x.reset = r; x.abort = a; x.start = s; x.take = t; x.gv = g; x.hit = h;
      return x;
   endfunction

   function automatic out_t mo(input int cm, cb, rd, bw, go, mk, br, pa, gc, rc);
      out_t o;
      o.cm = cm; o.cb = cb; o.rd = rd; o.bw = bw; o.go = go;
      o.mk = mk; o.br = br; o.pa = pa; o.gc = gc; o.rc = rc;
      return o;
   endfunction

   function automatic out_t get_out(input int d);
      if (d == 0)
         return mo(int'(cm0), int'(cb0), int'(rd0), int'(bw0), int'(go0),
                   int'(maker0), int'(breaker0), int'(pa0), int'(gc0), int'(rc0));
      return mo(int'(cm1), int'(cb1), int'(rd1), int'(bw1), int'(go1),
                int'(maker1), int'(breaker1), int'(pa1), int'(gc1), int'(rc1));
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic cmp(input string tag, input out_t a, input out_t e);
      check({tag, ".code_maker"},    a.cm, e.cm);
      check({tag, ".code_breaker"},  a.cb, e.cb);
      check({tag, ".round_done"},    a.rd, e.rd);
      check({tag, ".breaker_won"},   a.bw, e.bw);
      check({tag, ".game_over"},     a.go, e.go);
      check({tag, ".maker_id"},      a.mk, e.mk);
      check({tag, ".breaker_id"},    a.br, e.br);
      check({tag, ".player_active"}, a.pa, e.pa);
      check({tag, ".guess_cnt"},     a.gc, e.gc);
      check({tag, ".round_cnt"},     a.rc, e.rc);
   endtask

   // ---------------- reference model ----------------
   // States: 0 IDLE, 1 MAKE, 2 BREAK, 3 ROUND_END, 4 GAME_OVER
   function automatic out_t model_out(input int d);
      int br;
      int pa;
      br = (m_mk[d] + 1) % np[d];
      pa = (m_st[d] == 1) ? (1 << m_mk[d]) : (m_st[d] == 2) ? (1 << br) : 0;
      return mo(int'(m_st[d] == 1), int'(m_st[d] == 2), int'(m_st[d] == 3),
                m_bw[d], int'(m_st[d] == 4), m_mk[d], br, pa, m_gc[d], m_rc[d]);
   endfunction

   task automatic model_clear(input int d);
      m_mk[d] = 0; m_gc[d] = 0; m_rc[d] = 0; m_bw[d] = 0;
   endtask

   task automatic model_step(input int d, input inp_t in);
      bit last;
      if (in.reset || (in.abort && m_st[d] != 0)) begin
         m_st[d] = 0;
         model_clear(d);
      end else begin
         case (m_st[d])
            0, 4: if (in.start) begin m_st[d] = 1; model_clear(d); end
            1: if (in.take) m_st[d] = 2;
            2: if (in.gv) begin
                  last = (m_gc[d] == MG - 1);
                  m_gc[d]++;
                  if (in.hit || last) begin
                     m_st[d] = 3;
                     m_bw[d] = int'(in.hit);
                  end
               end
            3: if (m_rc[d] == nr[d] - 1) m_st[d] = 4;
               else begin
                  m_st[d] = 1;
                  m_rc[d]++;
                  m_gc[d] = 0;
                  m_bw[d] = 0;
                  m_mk[d] = (m_mk[d] + 1) % np[d];
               end
            default: m_st[d] = 0;
         endcase
      end
   endtask

   // ---------------- stimulus ----------------
   // Drive on the falling edge, check hold before the rising edge, then
   // drain the scoreboard after it. hand_dut >= 0 adds a hand-written
   // expectation for that instance.
   task automatic step(input inp_t in, input string tag,
                       input int hand_dut, input out_t hand);
      out_t prev[2];
      sb_t  e;
      @(negedge clk);
      reset = in.reset; abort = in.abort; start = in.start;
      take_code = in.take; guess_valid = in.gv; guess_hit = in.hit;
      for (int d = 0; d < 2; d++) begin
         prev[d] = model_out(d);
         model_step(d, in);
         sbq.push_back('{d, model_out(d), $sformatf("%s.dut%0d", tag, d)});
      end
      if (hand_dut >= 0)
         sbq.push_back('{hand_dut, hand, $sformatf("%s.hand%0d", tag, hand_dut)});
      #1;
      if (!first)
         for (int d = 0; d < 2; d++)
            cmp($sformatf("%s.pre_edge%0d", tag, d), get_out(d), prev[d]);
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         cmp(e.tag, get_out(e.dut), e.exp);
      end
      first = 1'b0;
   endtask

   task automatic go(input inp_t in, input string tag);
      step(in, tag, -1, mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic go_h(input inp_t in, input string tag, input out_t hand);
      step(in, tag, 0, hand);
   endtask

   task automatic misses(input int n, input string tag);
      for (int i = 0; i < n; i++) go(mi(0, 0, 0, 0, 1, 0), tag);
   endtask

   initial begin
      // Reset, first round, hit on the third guess, then ignored inputs.
      //                    r  a  s  t  g  h        cm cb rd bw go mk br pa gc rc
      tbl[0] = '{mi(1, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
      tbl[1] = '{mi(0, 0, 1, 0, 0, 0), mo(1, 0, 0, 0, 0, 0, 1, 1, 0, 0)};
      tbl[2] = '{mi(0, 0, 0, 1, 0, 0), mo(0, 1, 0, 0, 0, 0, 1, 2, 0, 0)};
      tbl[3] = '{mi(0, 0, 0, 0, 1, 0), mo(0, 1, 0, 0, 0, 0, 1, 2, 1, 0)};
      tbl[4] = '{mi(0, 0, 0, 0, 1, 0), mo(0, 1, 0, 0, 0, 0, 1, 2, 2, 0)};
      tbl[5] = '{mi(0, 0, 0, 0, 1, 1), mo(0, 0, 1, 1, 0, 0, 1, 0, 3, 0)};
      tbl[6] = '{mi(0, 0, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 1, 0, 2, 0, 1)};
      tbl[7] = '{mi(0, 0, 0, 0, 1, 0), mo(1, 0, 0, 0, 0, 1, 0, 2, 0, 1)};
      tbl[8] = '{mi(0, 0, 1, 0, 0, 0), mo(1, 0, 0, 0, 0, 1, 0, 2, 0, 1)};
      tbl[9] = '{mi(0, 0, 0, 1, 0, 0), mo(0, 1, 0, 0, 0, 1, 0, 1, 0, 1)};
      for (int d = 0; d < 2; d++) begin
         m_st[d] = 0;
         model_clear(d);
      end
      for (int i = 0; i < 10; i++) go_h(tbl[i].in, $sformatf("tbl%0d", i), tbl[i].exp);

      // Round 2: ten misses exhaust the round; a guess in ROUND_END is ignored.
      misses(9, "r2_miss");
      go_h(mi(0, 0, 0, 0, 1, 0), "r2_tenth", mo(0, 0, 1, 0, 0, 1, 0, 0, 10, 1));
      go_h(mi(0, 0, 0, 0, 1, 0), "r2_gv_in_end", mo(1, 0, 0, 0, 0, 0, 1, 1, 0, 2));

      // Round 3: hit on the tenth guess counts as a hit.
      go(mi(0, 0, 0, 1, 0, 0), "r3_take");
      misses(9, "r3_miss");
      go_h(mi(0, 0, 0, 0, 1, 1), "r3_hit10", mo(0, 0, 1, 1, 0, 0, 1, 0, 10, 2));
      go(mi(0, 0, 0, 0, 0, 0), "r3_next");

      // Round 4: final round leads to GAME_OVER, then a fresh start.
      go(mi(0, 0, 0, 1, 0, 0), "r4_take");
      go(mi(0, 0, 0, 0, 1, 1), "r4_hit");
      go_h(mi(0, 0, 0, 0, 0, 0), "game_over", mo(0, 0, 0, 1, 1, 1, 0, 0, 1, 3));
      go(mi(0, 0, 0, 1, 1, 0), "go_ignore");
      go_h(mi(0, 0, 1, 0, 0, 0), "restart", mo(1, 0, 0, 0, 0, 0, 1, 1, 0, 0));

      // Abort at guess_cnt = 5, then abort in IDLE does nothing.
      go(mi(0, 0, 0, 1, 0, 0), "ab_take");
      misses(5, "ab_miss");
      go_h(mi(0, 1, 0, 0, 0, 0), "abort", mo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      go_h(mi(0, 1, 0, 0, 0, 0), "abort_idle", mo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

      // Same with reset; pre-edge comparison shows no effect before the edge.
      go(mi(0, 0, 1, 0, 0, 0), "rs_start");
      go(mi(0, 0, 0, 1, 0, 0), "rs_take");
      misses(5, "rs_miss");
      go_h(mi(1, 0, 0, 0, 0, 0), "reset_mid", mo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

      // Three players over five rounds: maker/breaker rotation.
      go(mi(0, 0, 1, 0, 0, 0), "n3_start");
      for (int r = 0; r < 5; r++) begin
         check($sformatf("n3_maker_r%0d", r), int'(maker1), mk_seq[r]);
         check($sformatf("n3_breaker_r%0d", r), int'(breaker1), br_seq[r]);
         go(mi(0, 0, 0, 0, 1, 0), "n3_gv_make");
         check($sformatf("n3_gc_in_make_r%0d", r), int'(gc1), 0);
         go(mi(0, 0, 0, 1, 0, 0), "n3_take");
         go(mi(0, 0, 0, 0, 1, 1), "n3_hit");
         go(mi(0, 0, 0, 0, 0, 0), "n3_next");
      end
      check("n3_game_over", int'(go1), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
